wishbone_rr_arbiter: RTL and testbench

- Shares one Wishbone slave port between NM bus masters (CPU, debug, DMA) with round-robin arbitration.
- Placed between the masters and the single master port of the wishbone_crossbar, so the crossbar keeps NM=1.
- Holds a grant for a master's whole cyc period.
- Includes a bus watchdog that terminates stalled transfers with err.

---
 rtl/wishbone_rr_arbiter_if.sv | 48 ++++
 rtl/wishbone_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_rr_arbiter_if.sv
// Bundle of the per-master request/response lanes and the shared slave port.
// The arbiter uses the slave modport because it answers the masters' requests.
// The environment (masters plus downstream slave) uses the master modport.
interface wishbone_rr_arbiter_if #(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8,
    parameter int TW = 3
);
    // master-facing lanes
    logic [NM-1:0]    m_cyc;
    logic [NM-1:0]    m_stb;
    logic [NM-1:0]    m_we;
    logic [NM*TW-1:0] m_tag;
    logic [NM*SW-1:0] m_sel;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_mosi;
    logic [NM*DW-1:0] m_miso;
    logic [NM-1:0]    m_ack;
    logic [NM-1:0]    m_err;

    // shared downstream slave port
    logic             s_cyc;
    logic             s_stb;
    logic             s_we;
    logic [TW-1:0]    s_tag;
    logic [SW-1:0]    s_sel;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    s_mosi;
    logic [DW-1:0]    s_miso;
    logic             s_ack;
    logic             s_err;

    modport slave (
        input  m_cyc, m_stb, m_we, m_tag, m_sel, m_adr, m_mosi,
        output m_miso, m_ack, m_err,
        output s_cyc, s_stb, s_we, s_tag, s_sel, s_adr, s_mosi,
        input  s_miso, s_ack, s_err
    );

    modport master (
        output m_cyc, m_stb, m_we, m_tag, m_sel, m_adr, m_mosi,
        input  m_miso, m_ack, m_err,
        input  s_cyc, s_stb, s_we, s_tag, s_sel, s_adr, s_mosi,
        output s_miso, s_ack, s_err
    );
endinterface

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port.
// A grant is held for the owner's whole cyc period; a watchdog aborts
// strobes that wait too long for ack/err by returning err to the owner.
module wishbone_rr_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TW      = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    wishbone_rr_arbiter_if.slave  bus,
    output logic [NM-1:0]         grant,
    output logic                  timeout_evt
);
    localparam int PW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_reg, state_next;
    logic [NM-1:0]  grant_reg, grant_next;
    logic [NM-1:0]  pick_onehot;
    logic [PW-1:0]  ptr_reg, ptr_next;
    logic [PW-1:0]  owner_reg, owner_next;
    logic [PW-1:0]  pick;
    logic [PW-1:0]  scan_idx;
    logic           pick_valid;
    logic           busy;
    logic           own_stb;
    logic           abort;

    assign busy    = (state_reg == BUSY);
    assign own_stb = busy & bus.m_stb[owner_reg];

    // Round-robin scan: first requester at or after ptr, wrapping modulo NM.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NM; i++) begin
            scan_idx = PW'((int'(ptr_reg) + i) % NM);
            if (!pick_valid && bus.m_cyc[scan_idx]) begin
                pick_valid = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : gen_lane
            assign pick_onehot[gi]          = (pick == PW'(gi));
            // Read data is broadcast; masters qualify it with their own ack.
            assign bus.m_miso[gi*DW +: DW]  = bus.s_miso;
            assign bus.m_ack[gi]            = grant_reg[gi] & bus.s_ack;
            assign bus.m_err[gi]            = grant_reg[gi] & (bus.s_err | abort);
        end
    endgenerate

    // Next-state logic: grant in IDLE, hold until owner drops cyc, then rotate ptr.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = BUSY;
                    grant_next = pick_onehot;
                    owner_next = pick;
                end
            end
            BUSY: begin
                if (!bus.m_cyc[owner_reg]) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = (owner_reg == PW'(NM - 1)) ? '0 : owner_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

    generate
        if (TIMEOUT > 0) begin : gen_wd
            logic [CW-1:0] wd_cnt_reg, wd_cnt_next;
            logic          stall;

            // A stall cycle is a strobe without any response; ack on the
            // limit cycle therefore suppresses the abort.
            assign stall = own_stb & ~bus.s_ack & ~bus.s_err;
            assign abort = stall & (wd_cnt_reg == CW'(TIMEOUT - 1));

            // Count consecutive stall cycles; clear on response, stb low, abort or release.
            always_comb begin
                wd_cnt_next = '0;
                if (stall && !abort && state_next == BUSY)
                    wd_cnt_next = wd_cnt_reg + 1'b1;
            end

            // Watchdog counter register.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n)
                    wd_cnt_reg <= '0;
                else
                    wd_cnt_reg <= wd_cnt_next;
            end
        end else begin : gen_no_wd
            assign abort = 1'b0;
        end
    endgenerate

    // Slave side follows the owner combinationally; all zero while idle.
    assign bus.s_cyc  = busy & bus.m_cyc[owner_reg];
    assign bus.s_stb  = own_stb & ~abort;
    assign bus.s_we   = busy & bus.m_we[owner_reg];
    assign bus.s_tag  = busy ? bus.m_tag[owner_reg*TW +: TW]  : '0;
    assign bus.s_sel  = busy ? bus.m_sel[owner_reg*SW +: SW]  : '0;
    assign bus.s_adr  = busy ? bus.m_adr[owner_reg*AW +: AW]  : '0;
    assign bus.s_mosi = busy ? bus.m_mosi[owner_reg*DW +: DW] : '0;

    assign grant       = grant_reg;
    assign timeout_evt = abort;
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Scoreboard bench for wishbone_rr_arbiter (NM=2, TIMEOUT=4).
// Stimulus pushes hand-computed expectations; the monitor pops one whenever
// the grant changes, a response/timeout appears, or a probe is requested.
module tb_wishbone_rr_arbiter;
    localparam int NM      = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TW      = 3;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic [1:0]  grant;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic        evt;
        logic        scyc;
        logic        sstb;
        logic [31:0] adr;
        logic [31:0] miso;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [NM-1:0] grant;
    logic          timeout_evt;
    logic          probe;
    logic          done;
    logic [NM-1:0] prev_grant;
    int            errors;
    int            checks;
    exp_t          exp_q[$];
    string         name_q[$];

    wishbone_rr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TW(TW)) bus();

    wishbone_rr_arbiter #(
        .NM(NM), .AW(AW), .DW(DW), .SW(SW), .TW(TW), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .bus         (bus),
        .grant       (grant),
        .timeout_evt (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic expect_ev(input string nm, input logic [1:0] g, input logic [1:0] a,
                             input logic [1:0] e, input logic ev, input logic c,
                             input logic s, input logic [31:0] adr, input logic [31:0] miso);
        exp_t x;
        x.grant = g; x.ack = a; x.err = e; x.evt = ev;
        x.scyc = c; x.sstb = s; x.adr = adr; x.miso = miso;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic [31:0] adr);
        bus.m_cyc[i]             = cyc;
        bus.m_stb[i]             = stb;
        bus.m_we[i]              = 1'b0;
        bus.m_adr[i*AW +: AW]    = adr;
        bus.m_sel[i*SW +: SW]    = '1;
        bus.m_tag[i*TW +: TW]    = TW'(i);
        bus.m_mosi[i*DW +: DW]   = 32'h0;
    endtask

    task automatic slave(input logic ack, input logic err, input logic [31:0] miso);
        bus.s_ack  = ack;
        bus.s_err  = err;
        bus.s_miso = miso;
    endtask

    // Monitor: pop and compare whenever the DUT presents something observable.
    always @(negedge clk) begin
        exp_t  x;
        string n;
        logic  ev;
        logic  miso_ok;
        ev = (grant != prev_grant) || (|bus.m_ack) || (|bus.m_err) || timeout_evt || probe;
        if (ev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: grant=%b ack=%b err=%b evt=%b, required no event",
                         grant, bus.m_ack, bus.m_err, timeout_evt);
            end else begin
                x = exp_q.pop_front();
                n = name_q.pop_front();
                miso_ok = (x.ack == 2'b00) ||
                          ((bus.m_miso[31:0] == x.miso) && (bus.m_miso[63:32] == x.miso));
                if (grant !== x.grant || bus.m_ack !== x.ack || bus.m_err !== x.err ||
                    timeout_evt !== x.evt || bus.s_cyc !== x.scyc || bus.s_stb !== x.sstb ||
                    bus.s_adr !== x.adr || !miso_ok) begin
                    errors++;
                    $display("FAIL %s: got grant=%b ack=%b err=%b evt=%b cyc=%b stb=%b adr=%h miso=%h, required grant=%b ack=%b err=%b evt=%b cyc=%b stb=%b adr=%h miso=%h",
                             n, grant, bus.m_ack, bus.m_err, timeout_evt, bus.s_cyc, bus.s_stb,
                             bus.s_adr, bus.m_miso[31:0], x.grant, x.ack, x.err, x.evt,
                             x.scyc, x.sstb, x.adr, x.miso);
                end else begin
                    $display("ok   %s: grant=%b ack=%b err=%b evt=%b cyc=%b stb=%b adr=%h",
                             n, grant, bus.m_ack, bus.m_err, timeout_evt, bus.s_cyc,
                             bus.s_stb, bus.s_adr);
                end
            end
        end
        prev_grant = grant;
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_events: got %0d pending, required 0", exp_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish, required finish");
        $fatal(1, "time limit");
    end

    initial begin
        errors = 0;
        checks = 0;
        prev_grant = '0;
        probe = 1'b0;
        done  = 1'b0;
        rst_n = 1'b1;
        bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0; bus.m_tag = '0;
        bus.m_sel = '0; bus.m_adr = '0; bus.m_mosi = '0;
        slave(1'b0, 1'b0, 32'h0);
        #1 rst_n = 1'b0;

        // Reset state
        cycle(); probe = 1'b1; expect_ev("reset_state", 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 32'h0);
        cycle();
        cycle(); rst_n = 1'b1;

        // Single master read
        cycle(); set_m(0, 1, 1, 32'h10);
        cycle(); expect_ev("a_grant", 2'b01, 2'b00, 2'b00, 0, 1, 1, 32'h10, 32'h0);
        cycle(); slave(1, 0, 32'hDEADBEEF);
                 expect_ev("a_ack", 2'b01, 2'b01, 2'b00, 0, 1, 1, 32'h10, 32'hDEADBEEF);
        cycle(); slave(0, 0, 32'h0); set_m(0, 0, 0, 32'h10);
        cycle(); expect_ev("a_release", 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 32'h0);

        // Reset to bring ptr back to 0
        cycle(); rst_n = 1'b0;
        cycle(); rst_n = 1'b1;

        // Contention and fairness
        cycle(); set_m(0, 1, 1, 32'h100); set_m(1, 1, 1, 32'h200);
        cycle(); expect_ev("b_grant_m0", 2'b01, 2'b00, 2'b00, 0, 1, 1, 32'h100, 32'h0);
        cycle(); set_m(0, 0, 0, 32'h100);
        cycle(); expect_ev("b_gap", 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 32'h0);
                 set_m(0, 1, 1, 32'h100);
        cycle(); expect_ev("b_grant_m1", 2'b10, 2'b00, 2'b00, 0, 1, 1, 32'h200, 32'h0);
        cycle(); slave(1, 0, 32'h11112222);
                 expect_ev("b_ack_m1", 2'b10, 2'b10, 2'b00, 0, 1, 1, 32'h200, 32'h11112222);
        cycle(); slave(0, 0, 32'h0); set_m(1, 0, 0, 32'h200);
        cycle(); expect_ev("b_gap2", 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 32'h0);
        cycle(); expect_ev("b_grant_m0_again", 2'b01, 2'b00, 2'b00, 0, 1, 1, 32'h100, 32'h0);

        // Lock: three beats for M0 while M1 requests
        for (int k = 1; k <= 3; k++) begin
            cycle();
            set_m(1, 1, 1, 32'h200);
            set_m(0, 1, 1, 32'h100 + 32'(4 * k));
            slave(1, 0, 32'hA0 + 32'(k));
            expect_ev($sformatf("c_beat%0d", k), 2'b01, 2'b01, 2'b00, 0, 1, 1,
                      32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
        end
        cycle(); slave(0, 0, 32'h0); set_m(0, 0, 0, 32'h0);
        cycle(); expect_ev("c_gap", 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 32'h0);
        cycle(); expect_ev("c_grant_m1", 2'b10, 2'b00, 2'b00, 0, 1, 1, 32'h200, 32'h0);

        // Reset mid-transfer
        cycle(); rst_n = 1'b0; set_m(0, 1, 1, 32'h300);
                 expect_ev("e_reset_drop", 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 32'h0);
        cycle(); rst_n = 1'b1;
        cycle(); expect_ev("e_grant_after_reset", 2'b01, 2'b00, 2'b00, 0, 1, 1, 32'h300, 32'h0);

        // Slave err on M1
        cycle(); set_m(0, 0, 0, 32'h0);
        cycle(); expect_ev("f_gap", 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 32'h0);
        cycle(); expect_ev("f_grant_m1", 2'b10, 2'b00, 2'b00, 0, 1, 1, 32'h200, 32'h0);
        cycle(); slave(0, 1, 32'h0);
                 expect_ev("f_err", 2'b10, 2'b00, 2'b10, 0, 1, 1, 32'h200, 32'h0);
        cycle(); slave(0, 0, 32'h0); set_m(1, 0, 0, 32'h0);
        cycle(); expect_ev("f_release", 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 32'h0);
                 set_m(0, 1, 1, 32'h400);

        // Watchdog abort on 4th stall cycle, then ack exactly on the limit
        cycle(); expect_ev("d_grant", 2'b01, 2'b00, 2'b00, 0, 1, 1, 32'h400, 32'h0);
        cycle();
        cycle();
        cycle(); expect_ev("d_timeout", 2'b01, 2'b00, 2'b01, 1, 1, 0, 32'h400, 32'h0);
        cycle();
        cycle();
        cycle();
        cycle(); slave(1, 0, 32'h5A5A5A5A);
                 expect_ev("d_ack_at_limit", 2'b01, 2'b01, 2'b00, 0, 1, 1, 32'h400, 32'h5A5A5A5A);
        cycle(); slave(0, 0, 32'h0); set_m(0, 0, 0, 32'h0);
        cycle(); expect_ev("d_release", 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 32'h0);

        cycle();
        cycle();
        done = 1'b1;
        cycle();
    end
endmodule
